// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, constants and GF(2^8) helper for the AES-128 key schedule
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } state_t;

  typedef logic [31:0] word_t;
  typedef logic [7:0]  byte_t;

  localparam byte_t RCON_INIT  = 8'h01;
  localparam byte_t XTIME_POLY = 8'h1B;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic byte_t xtime(input byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - byte-level AES forward S-box, combinational table lookup
module aes_sbox (
  input  logic [7:0] data,
  output logic [7:0] subst
);

  // Ascending range so entry n sits at bits [8n +: 8], first table byte = entry 0.
  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign subst = SBOX_TABLE[{data, 3'b000} +: 8];

endmodule

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - SubWord: S-box applied to each byte of a 32-bit word
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t data,
  output word_t subst
);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .data  (data[8*i +: 8]),
      .subst (subst[8*i +: 8])
    );
  end

endmodule

// File: rtl/aes_key_expand_seq.sv
// rtl/aes_key_expand_seq.sv - sequential AES-128 key schedule, one round key per stream transfer
module aes_key_expand_seq
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int ROUND_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [127:0]       key_in,
  output logic               busy,
  output logic               rk_valid,
  input  logic               rk_ready,
  output logic [127:0]       rk_out,
  output logic [ROUND_W-1:0] rk_round,
  output logic               done
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);

  state_t state;
  byte_t  rcon;

  word_t w0, w1, w2, w3;
  word_t rot_w3, sub_w3, temp;
  word_t n0, n1, n2, n3;

  assign w0 = rk_out[127:96];
  assign w1 = rk_out[95:64];
  assign w2 = rk_out[63:32];
  assign w3 = rk_out[31:0];

  assign rot_w3 = {w3[23:0], w3[31:24]};

  aes_sub_word u_sub_word (
    .data  (rot_w3),
    .subst (sub_w3)
  );

  // Each new word folds in the previous new word, so n0..n3 form a ripple XOR chain.
  assign temp = sub_w3 ^ {rcon, 24'h0};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rk_out   <= '0;
      rk_round <= '0;
      rcon     <= RCON_INIT;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rk_out   <= key_in;
            rk_round <= '0;
            rcon     <= RCON_INIT;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (rk_valid && rk_ready) begin
            if (rk_round == LAST_ROUND) begin
              // Last key stays visible on rk_out/rk_round after the final transfer.
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              rk_out   <= {n0, n1, n2, n3};
              rk_round <= rk_round + 1'b1;
              rcon     <= xtime(rcon);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          rk_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
Sequential AES-128 key-schedule engine. It accepts a 128-bit cipher key and emits round keys 0..10, one per accepted transfer, on a valid/ready stream. This stream feeds the AddRoundKey stage directly upstream of the 16-byte substitution stage in the round datapath. SubWord reuses the existing byte-level sbox module through four instances.

Parameters:
NUM_ROUNDS, 10, last round-key index emitted; only 10 (AES-128) is supported, other values are illegal.
ROUND_W, 4, width of the round-index output.

Ports:
clk  input  1  single rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin expansion of key_in; honoured only in IDLE
key_in  input  128  cipher key; byte 0 = key_in[127:120], word w0 = key_in[127:96]
busy  output  1  high from the cycle after an accepted start until done
rk_valid  output  1  rk_out/rk_round hold a valid round key
rk_ready  input  1  consumer accepts the current round key when high with rk_valid
rk_out  output  128  round key; word order matches key_in
rk_round  output  ROUND_W  index of rk_out, 0..NUM_ROUNDS
done  output  1  one-cycle pulse after round NUM_ROUNDS is accepted

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rk_out=0, rk_round=0, rcon=8'h01.
  - rk_valid=0, busy=0, done=0.
  - Reset mid-expansion abandons it immediately; no done pulse.
- States: IDLE, EMIT, DONE.
- IDLE:
  - start=1 registers key_in into rk_out, rk_round=0, rcon=8'h01, rk_valid=1, busy=1, then goes to EMIT.
  - Latency from start to first rk_valid is 1 cycle.
- EMIT: rk_valid=1; rk_out and rk_round are held stable while rk_ready=0.
- Transfer (rk_valid & rk_ready) with rk_round<NUM_ROUNDS: on the same edge, load next key and rk_round+1; rcon=xtime(rcon).
  - Back-to-back accepts give one round key per cycle.
- Next-key computation, combinational from the current rk_out:
  - words w0..w3 = rk_out[127:96], [95:64], [63:32], [31:0].
  - RotWord(w3) = {w3[23:0], w3[31:24]}.
  - temp = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - n0 = w0^temp, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
- rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
- Transfer with rk_round==NUM_ROUNDS: rk_valid=0, state=DONE.
  - rk_out/rk_round retain their last value.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
- start while busy or in DONE is ignored; key_in is sampled only on an accepted start.
- rk_ready while rk_valid=0 has no effect.
- Exactly NUM_ROUNDS+1 transfers per start; no rounds are skipped or repeated regardless of rk_ready gaps.

Decomposition:
- Package aes_pkg:
  - state enum {IDLE, EMIT, DONE}.
  - RCON_INIT=8'h01, XTIME_POLY=8'h1B.
  - xtime function.
  - word/byte typedefs (word_t = logic[31:0]).
- Sub-module aes_sub_word: 32-bit in/out, four existing sbox instances, purely combinational.
- Top: FSM, rk_out/rk_round/rcon registers, next-key XOR chain.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1 → checks:
  - round 0 = key.
  - round 1 = a0fafe1788542cb123a339392a6c7605, round 2 = f2c295f27a96b9435935807a7359f67f.
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - 11 consecutive valid cycles, done pulses 1 cycle after round 10.
- All-zero key → round 1 = 62636363626363636263636362636363, round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Random rk_ready backpressure (≈50% duty) on the FIPS key → checks:
  - identical 11-key sequence.
  - rk_out/rk_round stable whenever rk_valid=1 and rk_ready=0.
- start pulsed with a different key_in during rounds 3 and 10 and in the DONE cycle → ignored; output sequence unchanged from the original key.
- rst_n asserted asynchronously mid-cycle at round 5 → checks:
  - immediately rk_valid=0, busy=0, rk_round=0, no done.
  - a new start then yields a correct full sequence from round 0.
- Two back-to-back expansions (start in the cycle after done) → second sequence correct, with rcon restarted at 01.
